seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle, parametrised non-restoring integer divider for the ALU's DIV path.
- Computes quotient and remainder for signed or unsigned operands of WIDTH bits, one quotient bit per clock.
- Uses a start/busy/done handshake so the control unit can stall while a divide runs.
- Result is packed as {quotient, remainder} and held until the next accepted start.

Parameters:
- WIDTH, 32, operand width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous, active-high reset
- start  input  1  request a divide; accepted only when busy=0
- signed_op  input  1  1=two's-complement operands, 0=unsigned; sampled with start
- dividend  input  WIDTH  dividend; sampled with start
- divisor  input  WIDTH  divisor; sampled with start
- busy  output  1  divide in progress
- done  output  1  one-cycle pulse; c valid from this cycle onward
- div_by_zero  output  1  registered with done; held with c
- c  output  2*WIDTH  {quotient[WIDTH-1:0], remainder[WIDTH-1:0]}

Behaviour:
- Reset (clr=1, any time, asynchronous): state=IDLE; busy=0, done=0, div_by_zero=0, c=0; internal A/Q/M/counter cleared. Reset mid-divide abandons the operation; no done pulse follows.
- States:
  - IDLE: start=1 at edge E0 latches operands.
    - If divisor==0, go to FIX with zero flag set.
    - Otherwise go to RUN with A=0, Q=|dividend|, M=|divisor|, count=0.
    - Magnitudes are taken only when signed_op=1 and the operand MSB=1; negation is modulo 2^WIDTH, so the most-negative value stays 0x80..0 and is treated as unsigned.
  - RUN: one non-restoring step per edge.
    - Shift {A,Q} left by 1.
    - If A >= 0: A = A - M; else A = A + M.
    - Q[0] = ~A[msb].
    - A is WIDTH+1 bits wide to avoid overflow.
    - After WIDTH steps (edge E_WIDTH), go to FIX.
  - FIX: single edge (E_WIDTH+1).
    - If A<0, A = A + M.
    - Signed mode: quotient negated when dividend sign XOR divisor sign; remainder takes the dividend's sign (truncating division, C semantics).
    - Register c, set done=1, go to IDLE.
- Divide by zero: c = {all-ones, dividend as given}, div_by_zero=1, done at edge E1. Applies in both modes.
- Signed overflow (min / -1): quotient=0x80..0, remainder=0, div_by_zero=0. This result falls out of the modulo magnitudes with no special case.
- Latency: done high in the cycle after edge E_WIDTH+1, i.e. WIDTH+2 cycles after start is sampled. Divide-by-zero takes 2 cycles.
- busy: high from the cycle after E0 until the edge that raises done (busy=0 in the done cycle).
- start while busy=1: ignored; operands are not re-sampled.
- start during the done cycle: accepted (back-to-back issue allowed).
- done is exactly one cycle wide. c and div_by_zero hold until the next FIX write.

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_OUT_EN.
- Defined: in IDLE at accept, if divisor != 0 and |dividend| < |divisor| (unsigned compare of magnitudes), skip RUN. Go directly to FIX with quotient=0 and remainder=original dividend (sign unchanged); done at edge E1.
- Not defined: every non-zero-divisor divide takes the full WIDTH+2 cycles; no comparator is synthesised.

Test Plan:
- WIDTH=32, unsigned 100/7 -> c=0x0000000E_00000002, done exactly 34 cycles after start, div_by_zero=0.
- Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> 0xFFFFFFFD / 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> c=0x80000000_00000000. Unsigned 0xFFFFFFFF/1 -> c=0xFFFFFFFF_00000000.
- Divisor 0, dividend 0x12345678 -> c=0xFFFFFFFF_12345678, div_by_zero=1, done 2 cycles after start.
- Second start pulse mid-RUN is ignored and the first result is unchanged. clr asserted at step 10 -> all outputs 0 immediately, no done. A new start after release completes normally.
- With SEQ_DIVIDER_EARLY_OUT_EN, 3/10 -> c=0x00000000_00000003 in 2 cycles. Without the macro, the same result arrives in 34 cycles.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: non-restoring signed/unsigned integer divider, one quotient bit per clock.
// Latency: done pulses WIDTH+2 cycles after start is accepted (2 cycles for divide-by-zero / early-out).
// Backpressure: start is ignored while busy=1; a start during the done cycle is accepted.
// Optional macro SEQ_DIVIDER_EARLY_OUT_EN: skip the iteration when |dividend| < |divisor|.
module seq_divider #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] c
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;        // partial remainder, one extra sign bit
  logic [WIDTH-1:0]   q_q, q_d;        // quotient bits; holds raw dividend on divide-by-zero
  logic [WIDTH-1:0]   m_q, m_d;        // divisor magnitude
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dz_q, dz_d;      // divisor was zero
  logic               negq_q, negq_d;  // quotient must be negated at the end
  logic               negr_q, negr_d;  // remainder must be negated at the end
  logic [2*WIDTH-1:0] c_q, c_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic               early;
  logic [WIDTH:0]     a_sh, a_step;
  logic [WIDTH-1:0]   a_fix, quo, rem;

  // Magnitudes are modulo 2^WIDTH, so the most-negative value maps onto itself.
  assign dvd_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  assign early = (dvd_mag < dvs_mag);
`else
  assign early = 1'b0;
`endif

  // One non-restoring step: the add/subtract choice follows the sign of A before the shift.
  assign a_sh   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign a_step = a_q[WIDTH] ? (a_sh + {1'b0, m_q}) : (a_sh - {1'b0, m_q});

  // Final correction lands in [0, M), so only the low WIDTH bits matter.
  assign a_fix = a_q[WIDTH-1:0] + (a_q[WIDTH] ? m_q : '0);
  assign quo   = negq_q ? -q_q : q_q;
  assign rem   = negr_q ? -a_fix : a_fix;

  // Next-state and datapath updates for the IDLE/RUN/FIX sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    c_d     = c_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          negq_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d = signed_op & dividend[WIDTH-1];
          m_d    = dvs_mag;
          cnt_d  = '0;
          if (divisor == '0) begin
            dz_d    = 1'b1;
            a_d     = '0;
            q_d     = dividend;
            state_d = S_FIX;
          end else if (early) begin
            // Quotient 0; remainder magnitude re-signed in FIX gives the original dividend.
            dz_d    = 1'b0;
            a_d     = {1'b0, dvd_mag};
            q_d     = '0;
            state_d = S_FIX;
          end else begin
            dz_d    = 1'b0;
            a_d     = '0;
            q_d     = dvd_mag;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        a_d = a_step;
        q_d = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          c_d   = {{WIDTH{1'b1}}, q_q};
          dbz_d = 1'b1;
        end else begin
          c_d   = {quo, rem};
          dbz_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; clr abandons any divide in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      c_q     <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      c_q     <= c_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign c           = c_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors for seq_divider (WIDTH=32) against an arithmetic reference model.
// The model tracks the start/busy/done handshake and is compared on every falling edge.
// Each vector also carries a hand-computed result and latency.
module tb_seq_divider;

  localparam int W = 32;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic          signed_op = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy, done, div_by_zero;
  logic [2*W-1:0] c;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .c(c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic with C-style truncating division.
  typedef struct packed {
    logic [63:0] c;
    logic        dz;
    logic [5:0]  lat;
  } exp_t;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   r;
    longint x, y, qq, rr;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    longint ma, mb;
`endif
    r.dz  = 1'b0;
    r.lat = 6'd34;
    r.c   = '0;
    if (b == 32'd0) begin
      r.c   = {32'hFFFFFFFF, a};
      r.dz  = 1'b1;
      r.lat = 6'd2;
    end else begin
      if (s) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end else begin
        x = longint'({32'd0, a});
        y = longint'({32'd0, b});
      end
      qq  = x / y;
      rr  = x % y;
      r.c = {qq[31:0], rr[31:0]};
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
      ma = (x < 0) ? -x : x;
      mb = (y < 0) ? -y : y;
      if (ma < mb) r.lat = 6'd2;
`endif
    end
    return r;
  endfunction

  exp_t        nx;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  bit          m_dbz = 1'b0;
  bit          m_pdz = 1'b0;
  logic [63:0] m_c = '0;
  logic [63:0] m_pc = '0;
  int          m_rem = 0;

  always_comb nx = model(dividend, divisor, signed_op);

  // Handshake-level model: accept when idle, raise done lat edges later.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0; m_c <= '0; m_rem <= 0;
    end else if (m_busy) begin
      if (m_rem == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_c <= m_pc; m_dbz <= m_pdz;
      end else begin
        m_rem  <= m_rem - 1;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_rem  <= int'(nx.lat) - 1;
        m_pc   <= nx.c;
        m_pdz  <= nx.dz;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("dbz", 64'(div_by_zero), 64'(m_dbz));
      chk("c", c, m_c);
    end
  end

  // Issue one divide, optionally with a junk start injected at step inj, then check hand values.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] ec, input logic ed, input int el, input int inj, input bit now);
    int cyc;
    bit got;
    if (!now) begin
      @(posedge clk); #2;
    end
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #2;
      if (cyc == 1) start = 1'b0;
      if (inj != 0 && cyc == inj) begin
        start = 1'b1; dividend = 32'd5; divisor = 32'd1; signed_op = 1'b0;
      end
      if (inj != 0 && cyc == inj + 1) start = 1'b0;
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk({nm, "_lat"}, 64'(cyc), 64'(el));
    chk({nm, "_c"}, c, ec);
    chk({nm, "_dbz"}, 64'(div_by_zero), 64'(ed));
  endtask

  initial begin
    int ndone;
    #1 clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_c", c, 64'd0);
    chk_en = 1'b1;
    @(posedge clk); #2 clr = 1'b0;

    run_op("u100_7",   32'd100,       32'd7,          1'b0, 64'h0000000E_00000002, 1'b0, 34, 0, 1'b0);
    run_op("s-7_2",    32'hFFFFFFF9,  32'd2,          1'b1, 64'hFFFFFFFD_FFFFFFFF, 1'b0, 34, 0, 1'b0);
    run_op("s7_-2",    32'd7,         32'hFFFFFFFE,   1'b1, 64'hFFFFFFFD_00000001, 1'b0, 34, 0, 1'b0);
    run_op("smin_-1",  32'h80000000,  32'hFFFFFFFF,   1'b1, 64'h80000000_00000000, 1'b0, 34, 0, 1'b0);
    run_op("umax_1",   32'hFFFFFFFF,  32'd1,          1'b0, 64'hFFFFFFFF_00000000, 1'b0, 34, 0, 1'b0);
    run_op("ubigdiv",  32'hFFFFFFFF,  32'h80000001,   1'b0, 64'h00000001_7FFFFFFE, 1'b0, 34, 0, 1'b0);
    run_op("s-100_-7", 32'hFFFFFF9C,  32'hFFFFFFF9,   1'b1, 64'h0000000E_FFFFFFFE, 1'b0, 34, 0, 1'b0);
    run_op("u3_10",    32'd3,         32'd10,         1'b0, 64'h00000000_00000003, 1'b0, EARLY_LAT, 0, 1'b0);
    run_op("s-3_10",   32'hFFFFFFFD,  32'd10,         1'b1, 64'h00000000_FFFFFFFD, 1'b0, EARLY_LAT, 0, 1'b0);
    run_op("udz",      32'h12345678,  32'd0,          1'b0, 64'hFFFFFFFF_12345678, 1'b1, 2, 0, 1'b0);
    run_op("sdz",      32'h80000000,  32'd0,          1'b1, 64'hFFFFFFFF_80000000, 1'b1, 2, 0, 1'b0);

    // Reset in the middle of a divide: outputs clear at once and no done follows.
    @(posedge clk); #2;
    dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_dbz", 64'(div_by_zero), 64'd0);
    chk("clr_c", c, 64'd0);
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("clr_no_done", 64'(ndone), 64'd0);

    // Fresh divide after reset, with a second start injected mid-RUN.
    run_op("u1000_3_inj", 32'd1000, 32'd3, 1'b0, 64'h0000014D_00000001, 1'b0, 34, 5, 1'b0);

    // Back-to-back: next start presented during the done cycle.
    run_op("b2b_a", 32'd100, 32'd7, 1'b0, 64'h0000000E_00000002, 1'b0, 34, 0, 1'b0);
    run_op("b2b_b", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFD_FFFFFFFF, 1'b0, 34, 0, 1'b1);

    // Result and flag must hold after done.
    repeat (5) @(negedge clk);
    chk("hold_c", c, 64'hFFFFFFFD_FFFFFFFF);
    chk("hold_done", 64'(done), 64'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

endmodule
